// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_pkg
// Brief    : Shared widths, FSM state encoding and ALU function codes.
// Revision : 1.0
// ============================================================================
package alu_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int FUNC_W_DEF = 3;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam logic [FUNC_W_DEF-1:0] FUNC_ADD  = 3'b000;
  localparam logic [FUNC_W_DEF-1:0] FUNC_SUB  = 3'b001;
  localparam logic [FUNC_W_DEF-1:0] FUNC_AND  = 3'b010;
  localparam logic [FUNC_W_DEF-1:0] FUNC_OR   = 3'b011;
  localparam logic [FUNC_W_DEF-1:0] FUNC_XOR  = 3'b100;
  localparam logic [FUNC_W_DEF-1:0] FUNC_SHL  = 3'b101;
  localparam logic [FUNC_W_DEF-1:0] FUNC_SHR  = 3'b110;
  localparam logic [FUNC_W_DEF-1:0] FUNC_PASS = 3'b111;

endpackage
`default_nettype wire

// File: rtl/alu_arbiter_alu.sv
`default_nettype none
// ============================================================================
// Module   : alu
// Brief    : Single-cycle combinational SISD ALU; outputs are all zero when
//            i_en is low. Overflow is signed overflow for add/sub, else 0.
// Revision : 1.0
// ============================================================================
module alu
  import alu_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int FUNC_W = FUNC_W_DEF
) (
  input  logic              i_en,
  input  logic [DATA_W-1:0] i_s1,
  input  logic [DATA_W-1:0] i_s2,
  input  logic [FUNC_W-1:0] i_func,
  output logic [DATA_W-1:0] o_result,
  output logic              o_zero,
  output logic              o_negative,
  output logic              o_overflow
);

  logic [DATA_W-1:0] result;
  logic              overflow;

  always_comb begin
    result   = '0;
    overflow = 1'b0;
    if (i_en) begin
      case (i_func)
        FUNC_ADD: begin
          result   = i_s1 + i_s2;
          overflow = (i_s1[DATA_W-1] == i_s2[DATA_W-1]) &&
                     (result[DATA_W-1] != i_s1[DATA_W-1]);
        end
        FUNC_SUB: begin
          result   = i_s1 - i_s2;
          overflow = (i_s1[DATA_W-1] != i_s2[DATA_W-1]) &&
                     (result[DATA_W-1] != i_s1[DATA_W-1]);
        end
        FUNC_AND:  result = i_s1 & i_s2;
        FUNC_OR:   result = i_s1 | i_s2;
        FUNC_XOR:  result = i_s1 ^ i_s2;
        FUNC_SHL:  result = {i_s1[DATA_W-2:0], 1'b0};
        FUNC_SHR:  result = {1'b0, i_s1[DATA_W-1:1]};
        default:   result = i_s1;
      endcase
    end
  end

  assign o_result   = result;
  assign o_zero     = i_en && (result == '0);
  assign o_negative = result[DATA_W-1];
  assign o_overflow = overflow;

endmodule
`default_nettype wire

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : alu_arbiter
// Brief    : Shares one alu between two requesters (IDLE -> EXEC -> RESP).
//            Define ALU_ARB_ROUND_ROBIN_EN for round-robin contention.
// Revision : 1.0
// ============================================================================
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int FUNC_W = FUNC_W_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_req0_valid,
  output logic              o_req0_ready,
  input  logic [DATA_W-1:0] i_req0_s1,
  input  logic [DATA_W-1:0] i_req0_s2,
  input  logic [FUNC_W-1:0] i_req0_func,
  input  logic              i_req1_valid,
  output logic              o_req1_ready,
  input  logic [DATA_W-1:0] i_req1_s1,
  input  logic [DATA_W-1:0] i_req1_s2,
  input  logic [FUNC_W-1:0] i_req1_func,
  output logic              o_rsp_valid,
  input  logic              i_rsp_ready,
  output logic              o_rsp_id,
  output logic [DATA_W-1:0] o_rsp_result,
  output logic              o_rsp_zero,
  output logic              o_rsp_negative,
  output logic              o_rsp_overflow
);

`ifdef ALU_ARB_ROUND_ROBIN_EN
  localparam logic c_RR_EN = 1'b1;
`else
  localparam logic c_RR_EN = 1'b0;
`endif

  logic [1:0]        state_q, state_d;
  logic [DATA_W-1:0] s1_q, s1_d;
  logic [DATA_W-1:0] s2_q, s2_d;
  logic [FUNC_W-1:0] func_q, func_d;
  logic              last_grant_q, last_grant_d;
  logic              rsp_id_q, rsp_id_d;
  logic [DATA_W-1:0] rsp_result_q, rsp_result_d;
  logic              rsp_zero_q, rsp_zero_d;
  logic              rsp_negative_q, rsp_negative_d;
  logic              rsp_overflow_q, rsp_overflow_d;

  logic              grant_en;
  logic              contention;
  logic              pick1;
  logic              xfer;
  logic              alu_en;
  logic [DATA_W-1:0] alu_result;
  logic              alu_zero;
  logic              alu_negative;
  logic              alu_overflow;

  // Readys are held low during reset even though state_q already reads IDLE.
  assign grant_en     = (state_q == ST_IDLE) && i_rst_n;
  assign contention   = i_req0_valid && i_req1_valid;
  assign pick1        = contention ? (c_RR_EN && !last_grant_q) : i_req1_valid;
  assign o_req0_ready = grant_en && i_req0_valid && !pick1;
  assign o_req1_ready = grant_en && i_req1_valid && pick1;
  assign xfer         = o_req0_ready || o_req1_ready;
  assign alu_en       = (state_q == ST_EXEC);

  alu #(
    .DATA_W (DATA_W),
    .FUNC_W (FUNC_W)
  ) u_alu (
    .i_en       (alu_en),
    .i_s1       (s1_q),
    .i_s2       (s2_q),
    .i_func     (func_q),
    .o_result   (alu_result),
    .o_zero     (alu_zero),
    .o_negative (alu_negative),
    .o_overflow (alu_overflow)
  );

  always_comb begin
    state_d        = state_q;
    s1_d           = s1_q;
    s2_d           = s2_q;
    func_d         = func_q;
    last_grant_d   = last_grant_q;
    rsp_id_d       = rsp_id_q;
    rsp_result_d   = rsp_result_q;
    rsp_zero_d     = rsp_zero_q;
    rsp_negative_d = rsp_negative_q;
    rsp_overflow_d = rsp_overflow_q;
    case (state_q)
      ST_IDLE: begin
        if (xfer) begin
          s1_d         = pick1 ? i_req1_s1   : i_req0_s1;
          s2_d         = pick1 ? i_req1_s2   : i_req0_s2;
          func_d       = pick1 ? i_req1_func : i_req0_func;
          last_grant_d = pick1;
          state_d      = ST_EXEC;
        end
      end
      ST_EXEC: begin
        // last_grant_q holds the id of the op in flight.
        rsp_id_d       = last_grant_q;
        rsp_result_d   = alu_result;
        rsp_zero_d     = alu_zero;
        rsp_negative_d = alu_negative;
        rsp_overflow_d = alu_overflow;
        state_d        = ST_RESP;
      end
      ST_RESP: begin
        if (i_rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q        <= ST_IDLE;
      s1_q           <= '0;
      s2_q           <= '0;
      func_q         <= '0;
      last_grant_q   <= 1'b1;
      rsp_id_q       <= 1'b0;
      rsp_result_q   <= '0;
      rsp_zero_q     <= 1'b0;
      rsp_negative_q <= 1'b0;
      rsp_overflow_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      s1_q           <= s1_d;
      s2_q           <= s2_d;
      func_q         <= func_d;
      last_grant_q   <= last_grant_d;
      rsp_id_q       <= rsp_id_d;
      rsp_result_q   <= rsp_result_d;
      rsp_zero_q     <= rsp_zero_d;
      rsp_negative_q <= rsp_negative_d;
      rsp_overflow_q <= rsp_overflow_d;
    end
  end

  assign o_rsp_valid    = (state_q == ST_RESP);
  assign o_rsp_id       = rsp_id_q;
  assign o_rsp_result   = rsp_result_q;
  assign o_rsp_zero     = rsp_zero_q;
  assign o_rsp_negative = rsp_negative_q;
  assign o_rsp_overflow = rsp_overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_arbiter
// Brief    : Self-checking bench for alu_arbiter; honours ALU_ARB_ROUND_ROBIN_EN.
// Revision : 1.0
// ============================================================================
module tb_alu_arbiter;

`ifdef ALU_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       v0, v1, rsp_ready;
  logic [7:0] a0, b0, a1, b1;
  logic [2:0] f0, f1;
  logic       o_req0_ready, o_req1_ready, o_rsp_valid, o_rsp_id;
  logic [7:0] o_rsp_result;
  logic       o_rsp_zero, o_rsp_negative, o_rsp_overflow;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  alu_arbiter #(.DATA_W(8), .FUNC_W(3)) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_req0_valid   (v0),
    .o_req0_ready   (o_req0_ready),
    .i_req0_s1      (a0),
    .i_req0_s2      (b0),
    .i_req0_func    (f0),
    .i_req1_valid   (v1),
    .o_req1_ready   (o_req1_ready),
    .i_req1_s1      (a1),
    .i_req1_s2      (b1),
    .i_req1_func    (f1),
    .o_rsp_valid    (o_rsp_valid),
    .i_rsp_ready    (rsp_ready),
    .o_rsp_id       (o_rsp_id),
    .o_rsp_result   (o_rsp_result),
    .o_rsp_zero     (o_rsp_zero),
    .o_rsp_negative (o_rsp_negative),
    .o_rsp_overflow (o_rsp_overflow)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference ALU from arithmetic on signed/unsigned integers.
  function automatic void ref_alu(input int f, input int a, input int b,
                                  output int r, output int z, output int n, output int v);
    int sa, sb, t;
    sa = (a > 127) ? a - 256 : a;
    sb = (b > 127) ? b - 256 : b;
    v  = 0;
    case (f)
      0: begin r = (a + b) % 256;       t = sa + sb; v = (t > 127 || t < -128) ? 1 : 0; end
      1: begin r = (a - b + 256) % 256; t = sa - sb; v = (t > 127 || t < -128) ? 1 : 0; end
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: r = (a * 2) % 256;
      6: r = a / 2;
      default: r = a;
    endcase
    z = (r == 0) ? 1 : 0;
    n = (r >= 128) ? 1 : 0;
  endfunction

  // Transaction-level model: one op in flight, response visible from its second cycle.
  bit m_busy = 0;
  int m_age  = 0;
  int m_last = 1;
  int p_f, p_a, p_b, p_id;
  int m_res = 0, m_z = 0, m_n = 0, m_v = 0, m_id = 0;

  always @(negedge clk) begin : p_cmp
    int win, r, z, n, v;
    if (rst_n !== 1'b1) begin
      chk("rst_ready0", o_req0_ready, 0);
      chk("rst_ready1", o_req1_ready, 0);
      chk("rst_rsp_valid", o_rsp_valid, 0);
      chk("rst_rsp_id", o_rsp_id, 0);
      chk("rst_result", o_rsp_result, 0);
      chk("rst_flags", {o_rsp_zero, o_rsp_negative, o_rsp_overflow}, 0);
      m_busy = 0; m_age = 0; m_last = 1;
      m_res = 0; m_z = 0; m_n = 0; m_v = 0; m_id = 0;
    end else begin
      win = -1;
      if (!m_busy) begin
        if (v0 && v1)  win = (RR && m_last == 0) ? 1 : 0;
        else if (v0)   win = 0;
        else if (v1)   win = 1;
      end
      chk("ready0", o_req0_ready, (win == 0) ? 1 : 0);
      chk("ready1", o_req1_ready, (win == 1) ? 1 : 0);
      chk("rsp_valid", o_rsp_valid, (m_busy && m_age >= 1) ? 1 : 0);
      chk("rsp_id", o_rsp_id, m_id);
      chk("rsp_result", o_rsp_result, m_res);
      chk("rsp_flags", {o_rsp_zero, o_rsp_negative, o_rsp_overflow}, m_z * 4 + m_n * 2 + m_v);
      if (m_busy) begin
        if (m_age == 0) begin
          ref_alu(p_f, p_a, p_b, r, z, n, v);
          m_res = r; m_z = z; m_n = n; m_v = v; m_id = p_id;
          m_age = 1;
        end else if (rsp_ready) begin
          m_busy = 0;
        end
      end else if (win >= 0) begin
        m_busy = 1; m_age = 0; m_last = win; p_id = win;
        p_f = (win == 0) ? int'(f0) : int'(f1);
        p_a = (win == 0) ? int'(a0) : int'(a1);
        p_b = (win == 0) ? int'(b0) : int'(b1);
      end
    end
  end

  task automatic send(input int who, input logic [2:0] f, input logic [7:0] a,
                      input logic [7:0] b, output int acc);
    @(posedge clk); #2;
    if (who == 0) begin v0 = 1; a0 = a; b0 = b; f0 = f; end
    else          begin v1 = 1; a1 = a; b1 = b; f1 = f; end
    acc = -1;
    for (int k = 0; k < 20 && acc < 0; k++) begin
      @(negedge clk);
      if ((who == 0 && o_req0_ready === 1'b1) || (who == 1 && o_req1_ready === 1'b1)) acc = cyc;
    end
    chk("send_accepted", (acc >= 0) ? 1 : 0, 1);
    @(posedge clk); #2;
    v0 = 0; v1 = 0;
  endtask

  task automatic expect_rsp(input string name, input int acc, input logic [7:0] res,
                            input logic z, input logic n, input logic v, input logic id);
    int seen = -1;
    for (int k = 0; k < 20 && seen < 0; k++) begin
      @(negedge clk);
      if (o_rsp_valid === 1'b1) seen = cyc;
    end
    chk({name, "_latency"}, seen - acc, 2);
    chk({name, "_result"}, o_rsp_result, res);
    chk({name, "_zero"}, o_rsp_zero, z);
    chk({name, "_negative"}, o_rsp_negative, n);
    chk({name, "_overflow"}, o_rsp_overflow, v);
    chk({name, "_id"}, o_rsp_id, id);
  endtask

  initial begin : p_main
    int acc, got;
    int order[4];
    bit acc0, acc1;
    rst_n = 0; v0 = 0; v1 = 0; rsp_ready = 1;
    a0 = 0; b0 = 0; f0 = 0; a1 = 0; b1 = 0; f1 = 0;
    repeat (2) @(posedge clk);
    #2 v0 = 1; v1 = 1;
    repeat (2) @(posedge clk);
    #2 v0 = 0; v1 = 0;
    @(posedge clk); #2 rst_n = 1;
    repeat (3) @(posedge clk);

    send(0, 3'b000, 8'h12, 8'h34, acc);
    expect_rsp("add_12_34", acc, 8'h46, 0, 0, 0, 0);
    send(1, 3'b000, 8'h7F, 8'h01, acc);
    expect_rsp("add_7f_01", acc, 8'h80, 0, 1, 1, 1);
    send(0, 3'b000, 8'hFF, 8'h01, acc);
    expect_rsp("add_ff_01", acc, 8'h00, 1, 0, 0, 0);

    // Fresh reset so the contention order starts from last_grant=1.
    @(posedge clk); #2 rst_n = 0;
    @(posedge clk); #2 rst_n = 1;
    a0 = 8'h01; b0 = 8'h02; f0 = 3'b000; a1 = 8'h10; b1 = 8'h20; f1 = 3'b000;
    v0 = 1; v1 = 1;
    got = 0;
    for (int k = 0; k < 40 && got < 4; k++) begin
      @(negedge clk);
      if (o_req0_ready === 1'b1)      begin order[got] = 0; got++; end
      else if (o_req1_ready === 1'b1) begin order[got] = 1; got++; end
    end
    @(posedge clk); #2 v0 = 0; v1 = 0;
    chk("contention_grants", got, 4);
    for (int i = 0; i < 4; i++) chk("contention_order", order[i], RR ? (i % 2) : 0);
    repeat (4) @(posedge clk);

    #2 rsp_ready = 0;
    send(1, 3'b001, 8'h05, 8'h09, acc);
    expect_rsp("sub_bp", acc, 8'hFC, 0, 1, 0, 1);
    @(posedge clk); #2 v0 = 1; v1 = 1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_valid_held", o_rsp_valid, 1);
      chk("bp_result_stable", o_rsp_result, 8'hFC);
      chk("bp_no_ready", {o_req0_ready, o_req1_ready}, 0);
    end
    @(posedge clk); #2 rsp_ready = 1;
    @(negedge clk);
    chk("bp_release_valid", o_rsp_valid, 1);
    chk("bp_release_no_ready", {o_req0_ready, o_req1_ready}, 0);
    @(negedge clk);
    chk("bp_consumed", o_rsp_valid, 0);
    @(posedge clk); #2 v0 = 0; v1 = 0;
    repeat (4) @(posedge clk);

    send(0, 3'b100, 8'hAA, 8'h55, acc);
    rst_n = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("rst_exec_no_valid", o_rsp_valid, 0);
    end
    @(posedge clk); #2 rst_n = 1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("post_rst_no_valid", o_rsp_valid, 0);
      chk("post_rst_no_ready", {o_req0_ready, o_req1_ready}, 0);
    end

    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      acc0 = v0 && (o_req0_ready === 1'b1);
      acc1 = v1 && (o_req1_ready === 1'b1);
      @(posedge clk); #2;
      if (!v0 || acc0) begin
        v0 = ($urandom_range(0, 2) != 0);
        a0 = 8'($urandom); b0 = 8'($urandom); f0 = 3'($urandom_range(0, 7));
      end else if ($urandom_range(0, 15) == 0) v0 = 0;
      if (!v1 || acc1) begin
        v1 = ($urandom_range(0, 2) != 0);
        a1 = 8'($urandom); b1 = 8'($urandom); f1 = 3'($urandom_range(0, 7));
      end else if ($urandom_range(0, 15) == 0) v1 = 0;
      rsp_ready = ($urandom_range(0, 3) != 0);
      if (!rst_n) rst_n = 1;
      else if ($urandom_range(0, 149) == 0) rst_n = 0;
    end
    rst_n = 1; v0 = 0; v1 = 0; rsp_ready = 1;
    repeat (5) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : p_watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
